round_robin_arbiter: RTL

Sequential round-robin arbiter that shares one resource among `width` requesters with grant locking and a bounded burst length. It wraps the combinational `FixedPriorityArbitor` (lowest index wins) and adds a rotating priority pointer, a registered one-hot grant and a per-grant hold counter. It sits in front of any shared bus or memory port that needs fair, glitch-free ownership.

---
 rtl/round_robin_arbiter_pkg.sv | 9 +
 rtl/round_robin_arbiter_if.sv | 25 ++
 rtl/round_robin_arbiter_fpa.sv | 12 +
 rtl/round_robin_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared types for the round-robin arbiter slice.
package round_robin_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_e;

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface round_robin_arbiter_if #(
    parameter int unsigned width = 2
);
    localparam int unsigned OW = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] i_request;
    logic [width-1:0] o_grant;
    logic             o_valid;
    logic [OW-1:0]    o_owner;

    modport master (
        output i_request,
        input  o_grant,
        input  o_valid,
        input  o_owner
    );

    modport slave (
        input  i_request,
        output o_grant,
        output o_valid,
        output o_owner
    );
endinterface

// File: rtl/round_robin_arbiter_fpa.sv
// Combinational fixed-priority arbiter: the lowest set request index wins.
module FixedPriorityArbitor #(
    parameter int unsigned width = 2
) (
    input  logic [width-1:0] i_request,
    output logic [width-1:0] o_grant
);
    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        o_grant = i_request & (~i_request + width'(1));
    end
endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant locking and bounded burst length.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned width     = 2,
    parameter int unsigned max_burst = 4
) (
    input logic                   clk,
    input logic                   rst,
    round_robin_arbiter_if.slave  bus
);
    localparam int unsigned OW = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned CW = $clog2(max_burst + 1);

    rr_state_e        state_q, state_d;
    logic [width-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [OW-1:0]    last_q, last_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    count_q, count_d;

    logic [width-1:0] cand, mask, win_masked, win_full, winner;
    logic [OW-1:0]    winner_idx;
    logic             holder_req, others, burst_left;

    // The current holder is removed from the candidates, so a burst-expiry
    // re-select can never hand the grant straight back to it.
    always_comb begin
        cand = bus.i_request & ~grant_q;
        mask = '0;
        for (int unsigned i = 0; i < width; i++) begin
            mask[i] = cand[i] && (OW'(i) > last_q);
        end
    end

    FixedPriorityArbitor #(.width(width)) u_fpa_masked (
        .i_request (mask),
        .o_grant   (win_masked)
    );

    FixedPriorityArbitor #(.width(width)) u_fpa_full (
        .i_request (cand),
        .o_grant   (win_full)
    );

    always_comb begin
        winner     = (|win_masked) ? win_masked : win_full;
        winner_idx = '0;
        for (int unsigned i = 0; i < width; i++) begin
            if (winner[i]) winner_idx = OW'(i);
        end
        holder_req = |(bus.i_request & grant_q);
        others     = |cand;
        burst_left = count_q < CW'(max_burst);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        owner_d = owner_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (others) begin
                    state_d = BUSY;
                    grant_d = winner;
                    last_d  = winner_idx;
                    owner_d = winner_idx;
                    count_d = CW'(1);
                end
            end
            BUSY: begin
                if (holder_req && (burst_left || !others)) begin
                    if (burst_left) count_d = count_q + CW'(1);
                end else if (others) begin
                    grant_d = winner;
                    last_d  = winner_idx;
                    owner_d = winner_idx;
                    count_d = CW'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            last_q  <= OW'(width - 1);
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_valid = valid_q;
    assign bus.o_owner = owner_q;
endmodule
